multi_edge_detect: RTL and testbench

Multi-channel, parametrised edge detector for asynchronous pulse inputs.
- Per channel: synchroniser, glitch filter, rising/falling/both-edge detection, sticky event flag with software clear.
- Sits between external pulse pins (buttons, sensor strobes, cross-domain flags) and the control FSMs or interrupt logic that consume single-cycle edge events.

---
 rtl/multi_edge_detect_pkg.sv | 17 +
 rtl/multi_edge_detect_edge_chan.sv | 102 ++++++++++
 rtl/multi_edge_detect.sv | 52 +++++
 tb/tb_multi_edge_detect.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_edge_detect_pkg.sv
// Shared definitions for the multi-channel edge detector: mode encodings and
// the filter counter width helper.
package multi_edge_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_t;

  // Counter must hold values up to FILT_CYCLES-1; never narrower than one bit.
  function automatic int filt_cnt_width(input int filt_cycles);
    return (filt_cycles < 1) ? 1 : $clog2(filt_cycles + 1);
  endfunction

endpackage

// File: rtl/multi_edge_detect_edge_chan.sv
// One channel: synchroniser, persistence filter, edge detection, sticky flags.
// Edges appear SYNC_STAGES+FILT_CYCLES-1 clocks after the first sampling edge.
module edge_chan
  import multi_edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pulse,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic       edge_evt,
  output logic       pending,
  output logic       overrun
);

  localparam int CW = filt_cnt_width(FILT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;
  logic                   accept;
  logic                   next_rise;
  logic                   next_fall;
  logic                   next_edge;
  logic                   on_rise;
  logic                   on_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pulse};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // Any return of s to the current level restarts the persistence count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (s == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= s;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    accept    = (s != level) && (cnt == CNT_LAST);
    next_rise = accept && s;
    next_fall = accept && !s;
    on_rise   = (mode == MODE_RISE) || (mode == MODE_BOTH);
    on_fall   = (mode == MODE_FALL) || (mode == MODE_BOTH);
    next_edge = (next_rise && on_rise) || (next_fall && on_fall);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise     <= 1'b0;
      fall     <= 1'b0;
      edge_evt <= 1'b0;
    end else begin
      rise     <= next_rise;
      fall     <= next_fall;
      edge_evt <= next_edge;
    end
  end

  // A new event beats a simultaneous clear so it is never lost; the clear
  // still wipes overrun because software has just acknowledged the backlog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (next_edge) begin
        pending <= 1'b1;
      end else if (clr) begin
        pending <= 1'b0;
      end

      if (next_edge && pending && !clr) begin
        overrun <= 1'b1;
      end else if (clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector for asynchronous pulse pins; channels are
// fully independent copies of edge_chan.
module multi_edge_detect
  import multi_edge_pkg::*;
#(
  parameter int CH_NUM      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH_NUM-1:0]   i_pulse,
  input  logic [2*CH_NUM-1:0] i_mode,
  input  logic [CH_NUM-1:0]   i_clr,
  output logic [CH_NUM-1:0]   o_level,
  output logic [CH_NUM-1:0]   o_rise,
  output logic [CH_NUM-1:0]   o_fall,
  output logic [CH_NUM-1:0]   o_edge,
  output logic [CH_NUM-1:0]   o_pending,
  output logic [CH_NUM-1:0]   o_overrun
);

  if (CH_NUM < 1) begin : g_bad_ch
    $fatal(1, "multi_edge_detect: CH_NUM must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "multi_edge_detect: SYNC_STAGES must be >= 2");
  end
  if (FILT_CYCLES < 1) begin : g_bad_filt
    $fatal(1, "multi_edge_detect: FILT_CYCLES must be >= 1");
  end

  for (genvar n = 0; n < CH_NUM; n++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYCLES(FILT_CYCLES)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .pulse   (i_pulse[n]),
      .mode    (i_mode[2*n +: 2]),
      .clr     (i_clr[n]),
      .level   (o_level[n]),
      .rise    (o_rise[n]),
      .fall    (o_fall[n]),
      .edge_evt(o_edge[n]),
      .pending (o_pending[n]),
      .overrun (o_overrun[n])
    );
  end

endmodule

// File: tb/tb_multi_edge_detect.sv
// Scoreboard bench: stimulus queues per-cycle expectations, a negedge monitor
// matches them against output events and flags unexpected ones.
module tb_multi_edge_detect;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pulse, clr;
  logic [7:0] mode;
  logic [3:0] level, rise, fall, edg, pend, ovr;

  logic [7:0]  pulse2, clr2;
  logic [15:0] mode2;
  logic [7:0]  level2, rise2, fall2, edg2, pend2, ovr2;

  always #5 clk = ~clk;

  multi_edge_detect #(.CH_NUM(4), .SYNC_STAGES(2), .FILT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_pulse(pulse), .i_mode(mode), .i_clr(clr),
    .o_level(level), .o_rise(rise), .o_fall(fall), .o_edge(edg),
    .o_pending(pend), .o_overrun(ovr)
  );

  multi_edge_detect #(.CH_NUM(8), .SYNC_STAGES(3), .FILT_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_pulse(pulse2), .i_mode(mode2), .i_clr(clr2),
    .o_level(level2), .o_rise(rise2), .o_fall(fall2), .o_edge(edg2),
    .o_pending(pend2), .o_overrun(ovr2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // v = {level, rise, fall, edge, pending, overrun} of one channel
  typedef struct {
    int         cyc;
    int         ch;
    logic [5:0] v;
    string      name;
  } exp_t;

  // v = {rise, fall, edge, level, pending, overrun}, all 8 channels
  typedef struct {
    int          cyc;
    logic [47:0] v;
    string       name;
  } exp2_t;

  exp_t  q[$];
  exp2_t q2[$];
  int    n_chk = 0;
  int    n_fail = 0;
  bit    done = 1'b0;

  function automatic void push(int t, int ch, logic [5:0] v, string name);
    exp_t e;
    e.cyc = t; e.ch = ch; e.v = v; e.name = name;
    q.push_back(e);
  endfunction

  function automatic void push2(int t, logic [47:0] v, string name);
    exp2_t e;
    e.cyc = t; e.v = v; e.name = name;
    q2.push_back(e);
  endfunction

  task automatic wait_cyc(int t);
    while (cyc < t) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  logic [5:0]  got;
  logic [47:0] got2;
  logic [3:0]  seen;
  bit          seen2;
  int          i;

  always @(negedge clk or negedge rst_n) begin
    if (clk) begin
      // reset asserted while clk high: outputs must clear before the next edge
      #1;
      n_chk++;
      if ({level, rise, fall, edg, pend, ovr} != 24'h0 ||
          {level2, rise2, fall2, edg2, pend2, ovr2} != 48'h0) begin
        n_fail++;
        $display("FAIL async_reset_clear: got dut=%h dut2=%h, expected all zero",
                 {level, rise, fall, edg, pend, ovr}, {level2, rise2, fall2, edg2, pend2, ovr2});
      end
    end else begin
      seen = '0;
      i = 0;
      while (i < q.size()) begin
        if (q[i].cyc == cyc) begin
          n_chk++;
          got = {level[q[i].ch], rise[q[i].ch], fall[q[i].ch], edg[q[i].ch], pend[q[i].ch], ovr[q[i].ch]};
          if (got !== q[i].v) begin
            n_fail++;
            $display("FAIL %s ch%0d cyc%0d: got lvl/r/f/e/p/o=%b expected %b",
                     q[i].name, q[i].ch, cyc, got, q[i].v);
          end
          seen[q[i].ch] = 1'b1;
          q.delete(i);
        end else if (q[i].cyc < cyc) begin
          n_chk++; n_fail++;
          $display("FAIL %s ch%0d: expectation for cyc%0d never evaluated", q[i].name, q[i].ch, q[i].cyc);
          q.delete(i);
        end else begin
          i++;
        end
      end
      for (int c = 0; c < 4; c++) begin
        if ((rise[c] || fall[c] || edg[c]) && !seen[c]) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_event ch%0d cyc%0d: got r/f/e=%b%b%b expected none",
                   c, cyc, rise[c], fall[c], edg[c]);
        end
      end

      seen2 = 1'b0;
      i = 0;
      while (i < q2.size()) begin
        if (q2[i].cyc == cyc) begin
          n_chk++;
          got2 = {rise2, fall2, edg2, level2, pend2, ovr2};
          if (got2 !== q2[i].v) begin
            n_fail++;
            $display("FAIL %s cyc%0d: got r/f/e/l/p/o=%h expected %h", q2[i].name, cyc, got2, q2[i].v);
          end
          seen2 = 1'b1;
          q2.delete(i);
        end else if (q2[i].cyc < cyc) begin
          n_chk++; n_fail++;
          $display("FAIL %s: expectation for cyc%0d never evaluated", q2[i].name, q2[i].cyc);
          q2.delete(i);
        end else begin
          i++;
        end
      end
      if ((rise2 | fall2 | edg2) != 8'h0 && !seen2) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_event_dut2 cyc%0d: got r/f/e=%h/%h/%h expected none",
                 cyc, rise2, fall2, edg2);
      end

      if (done) begin
        if (q.size() != 0 || q2.size() != 0) begin
          n_chk++; n_fail++;
          $display("FAIL leftover_expectations: got %0d pending entries expected 0", q.size() + q2.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int b;
    logic [1:0] mm;
    rst_n = 1'b0;
    pulse = '0; clr = '0;
    mode  = 8'b01_00_11_01;   // ch3 rise, ch2 off, ch1 both, ch0 rise
    pulse2 = '0; clr2 = '0; mode2 = '1;
    for (int c = 0; c < 4; c++) push(2, c, 6'b000000, "reset_state");
    wait_cyc(3);
    rst_n = 1'b1;

    // basic rise on ch0, latency SYNC+FILT-1 after first sampling edge
    wait_cyc(6);
    b = cyc;
    pulse[0] = 1'b1;
    push(b + 6, 0, 6'b110110, "ch0_rise");
    push(b + 7, 0, 6'b100010, "ch0_rise_one_cycle");
    wait_cyc(b + 9);

    // 3-cycle glitch on ch1 is swallowed
    b = cyc;
    pulse[1] = 1'b1;
    wait_cyc(b + 3);
    pulse[1] = 1'b0;
    push(b + 9, 1, 6'b000000, "glitch3_ignored");
    wait_cyc(b + 10);

    // 4-cycle pulse on ch1 is accepted; fall sets overrun (pending still set)
    b = cyc;
    pulse[1] = 1'b1;
    push(b + 6, 1, 6'b110110, "glitch4_rise");
    wait_cyc(b + 4);
    pulse[1] = 1'b0;
    push(b + 10, 1, 6'b001111, "glitch4_fall");
    wait_cyc(b + 12);

    // ch2 through every mode: rise/fall always, edge only where enabled
    for (int m = 0; m < 4; m++) begin
      mm = m[1:0];
      b = cyc;
      mode[5:4] = mm;
      clr[2] = 1'b1;
      wait_cyc(b + 1);
      clr[2] = 1'b0;
      pulse[2] = 1'b1;
      push(b + 7, 2, {1'b1, 1'b1, 1'b0, mm[0], mm[0], 1'b0}, "mode_rise");
      wait_cyc(b + 9);
      pulse[2] = 1'b0;
      push(b + 15, 2, {1'b0, 1'b0, 1'b1, mm[1], mm[0] | mm[1], mm[0] & mm[1]}, "mode_fall");
      wait_cyc(b + 17);
    end

    // sticky flags on ch3 (rise-only mode)
    b = cyc;
    pulse[3] = 1'b1;
    push(b + 6, 3, 6'b110110, "sticky_rise1");
    wait_cyc(b + 8);
    pulse[3] = 1'b0;
    push(b + 14, 3, 6'b001010, "sticky_fall1_no_edge");
    wait_cyc(b + 16);
    pulse[3] = 1'b1;
    push(b + 22, 3, 6'b110111, "sticky_rise2_overrun");
    wait_cyc(b + 24);
    pulse[3] = 1'b0;
    push(b + 30, 3, 6'b001011, "sticky_fall2_hold");
    wait_cyc(b + 32);
    pulse[3] = 1'b1;
    push(b + 38, 3, 6'b110110, "clr_with_edge");
    wait_cyc(b + 37);
    clr[3] = 1'b1;
    wait_cyc(b + 38);
    clr[3] = 1'b0;
    wait_cyc(b + 40);
    clr[3] = 1'b1;
    push(b + 41, 3, 6'b100000, "clr_alone");
    wait_cyc(b + 41);
    clr[3] = 1'b0;
    wait_cyc(b + 43);

    // async reset with ch1 filter mid-count; inputs high at release
    b = cyc;
    pulse[1] = 1'b1;
    wait_cyc(b + 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) push(b + 4, c, 6'b000000, "reset_hold");
    wait_cyc(b + 6);
    rst_n = 1'b1;
    push(b + 12, 0, 6'b110110, "release_high_ch0");
    push(b + 12, 1, 6'b110110, "release_high_ch1");
    push(b + 12, 3, 6'b110110, "release_high_ch3");
    wait_cyc(b + 14);

    // 8 channels, SYNC_STAGES=3, FILT_CYCLES=1: latency 3, simultaneous toggles
    b = cyc;
    pulse2 = 8'hA5;
    push2(b + 4, {8'hA5, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'h00}, "dut2_rise");
    push2(b + 5, {8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'h00}, "dut2_rise_one_cycle");
    wait_cyc(b + 4);
    pulse2 = 8'h5A;
    push2(b + 8, {8'h5A, 8'hA5, 8'hFF, 8'h5A, 8'hFF, 8'hA5}, "dut2_swap");
    wait_cyc(b + 10);

    done = 1'b1;
  end

endmodule
